// File: rtl/sdram_l1_cache.sv
// rtl/sdram_l1_cache.sv - direct-mapped, one-word-per-line, write-through L1 cache in front of an SDRAM controller
module sdram_l1_cache #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 24 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_start,
  input  logic        cache_clear,
  output logic [31:0] cpu_q,
  output logic        cpu_done,
  output logic        busy,
  output logic [23:0] sdc_addr,
  output logic [31:0] sdc_data,
  output logic        sdc_we,
  output logic        sdc_start,
  input  logic [31:0] sdc_q,
  input  logic        sdc_done
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, MEM_REQ, DONE_WAIT} state_t;

  state_t state, state_n;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic [LINES-1:0]      valid;

  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  rd_valid;

  logic [23:0]           req_addr;
  logic [31:0]           req_data;
  logic                  req_we;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;

  logic [INDEX_BITS-1:0] clr_cnt;
  logic                  clr_pend;

  logic                  accept;
  logic                  hit;
  logic                  line_we;
  state_t                exit_to;

  assign req_index = req_addr[INDEX_BITS-1:0];
  assign req_tag   = req_addr[23:INDEX_BITS];
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    hit     = 1'b0;
    line_we = 1'b0;
    // Any transaction that would return to IDLE sweeps first if a clear is owed
    exit_to = (clr_pend || cache_clear) ? CLEAR : IDLE;
    case (state)
      CLEAR: begin
        if (&clr_cnt) state_n = exit_to;
      end
      IDLE: begin
        if (cache_clear) begin
          state_n = CLEAR;
        end else if (cpu_start) begin
          accept  = 1'b1;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        hit     = rd_valid && (rd_tag == req_tag) && !req_we;
        state_n = hit ? exit_to : MEM_REQ;
      end
      MEM_REQ: begin
        if (sdc_done) begin
          line_we = 1'b1;
          state_n = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (!sdc_done) state_n = exit_to;
      end
      default: state_n = CLEAR;
    endcase
  end

  // Line storage: registered read launched on request acceptance, no reset (CLEAR sweeps valid)
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_tag   <= tag_mem[cpu_addr[INDEX_BITS-1:0]];
      rd_data  <= data_mem[cpu_addr[INDEX_BITS-1:0]];
      rd_valid <= valid[cpu_addr[INDEX_BITS-1:0]];
    end
    if (state == CLEAR) valid[clr_cnt] <= 1'b0;
    if (line_we) begin
      tag_mem[req_index]  <= req_tag;
      data_mem[req_index] <= req_we ? req_data : sdc_q;
      valid[req_index]    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      clr_pend  <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      req_we    <= 1'b0;
      cpu_q     <= '0;
      cpu_done  <= 1'b0;
      sdc_addr  <= '0;
      sdc_data  <= '0;
      sdc_we    <= 1'b0;
      sdc_start <= 1'b0;
    end else begin
      state    <= state_n;
      cpu_done <= 1'b0;
      clr_cnt  <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;

      if (state_n == CLEAR)
        clr_pend <= 1'b0;
      else if (cache_clear && state != IDLE)
        clr_pend <= 1'b1;

      if (accept) begin
        req_addr <= cpu_addr;
        req_data <= cpu_data;
        req_we   <= cpu_we;
      end

      if (state == LOOKUP) begin
        if (hit) begin
          cpu_q    <= rd_data;
          cpu_done <= 1'b1;
        end else begin
          sdc_addr  <= req_addr;
          sdc_data  <= req_data;
          sdc_we    <= req_we;
          sdc_start <= 1'b1;
        end
      end

      if (line_we) begin
        sdc_start <= 1'b0;
        cpu_done  <= 1'b1;
        if (!req_we) cpu_q <= sdc_q;
      end
    end
  end

endmodule

// File: tb/tb_sdram_l1_cache.sv
// tb/tb_sdram_l1_cache.sv - directed self-checking bench for sdram_l1_cache with a behavioural SDRAM controller
module tb_sdram_l1_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_we;
  logic        cpu_start;
  logic        cache_clear;
  logic [31:0] cpu_q;
  logic        cpu_done;
  logic        busy;
  logic [23:0] sdc_addr;
  logic [31:0] sdc_data;
  logic        sdc_we;
  logic        sdc_start;
  logic [31:0] sdc_q;
  logic        sdc_done;

  int n_pass  = 0;
  int n_total = 0;

  // SDRAM controller model state
  logic [31:0] sdram [logic [23:0]];
  int          n_req    = 0;
  int          done_len = 2;
  logic [23:0] last_addr;
  logic [31:0] last_data;
  logic        last_we;

  sdram_l1_cache dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_we      (cpu_we),
    .cpu_start   (cpu_start),
    .cache_clear (cache_clear),
    .cpu_q       (cpu_q),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .sdc_addr    (sdc_addr),
    .sdc_data    (sdc_data),
    .sdc_we      (sdc_we),
    .sdc_start   (sdc_start),
    .sdc_q       (sdc_q),
    .sdc_done    (sdc_done)
  );

  always #5 clk = ~clk;

  initial begin
    sdc_done = 1'b0;
    sdc_q    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sdc_start === 1'b1) begin
        n_req++;
        last_addr = sdc_addr;
        last_data = sdc_data;
        last_we   = sdc_we;
        if (sdc_we) sdram[sdc_addr] = sdc_data;
        @(posedge clk);
        #1;
        sdc_q    = sdram.exists(last_addr) ? sdram[last_addr] : 32'h0;
        sdc_done = 1'b1;
        repeat (done_len) @(posedge clk);
        #1;
        sdc_done = 1'b0;
        sdc_q    = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one request from a post-edge sample point and watches until idle
  task automatic req(input logic [23:0] a, input logic [31:0] d, input logic we, input int clr_at,
                     output logic [31:0] q, output int lat, output int ndone,
                     output int nbusy, output int nreq);
    int n0;
    int k;
    int idle_seen;
    n0 = n_req; lat = 0; ndone = 0; nbusy = 0; q = '0; idle_seen = 0; k = 0;
    cpu_addr = a; cpu_data = d; cpu_we = we; cpu_start = 1'b1;
    while (idle_seen < 4 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
      cpu_start   = 1'b0;
      cpu_addr    = $urandom;
      cpu_data    = $urandom;
      cpu_we      = $urandom_range(0, 1);
      cache_clear = (k == clr_at);
      if (cpu_done) begin
        ndone++;
        if (lat == 0) begin lat = k; q = cpu_q; end
      end
      if (busy) nbusy++;
      else if (lat != 0) idle_seen++;
    end
    cache_clear = 1'b0;
    nreq = n_req - n0;
  endtask

  task automatic wait_sweep(output int n, output int ndone);
    n = 0; ndone = 0;
    while (busy && n < 400) begin
      n++;
      if (cpu_done) ndone++;
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] q;
  int lat, ndone, nbusy, nreq, nsw;

  initial begin
    reset = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0;
    cpu_start = 1'b0; cache_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_q", cpu_q, 32'h0);
    chk("rst_cpu_done", {31'b0, cpu_done}, 32'h0);
    chk("rst_sdc_start", {31'b0, sdc_start}, 32'h0);
    chk("rst_sdc_addr", {8'b0, sdc_addr}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);

    reset = 1'b1;
    wait_sweep(nsw, ndone);
    chk("init_sweep_len", nsw, 128);

    sdram[24'h000010] = 32'hDEADBEEF;
    done_len = 2;
    req(24'h000010, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("miss_nreq", nreq, 1);
    chk("miss_sdc_addr", {8'b0, last_addr}, 32'h000010);
    chk("miss_sdc_we", {31'b0, last_we}, 32'h0);
    chk("miss_ndone", ndone, 1);
    chk("miss_q", q, 32'hDEADBEEF);
    chk("miss_lat", lat, 4);
    chk("miss_busy_done2", nbusy, 5);

    req(24'h000010, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("hit_lat", lat, 2);
    chk("hit_nreq", nreq, 0);
    chk("hit_q", q, 32'hDEADBEEF);
    chk("hit_ndone", ndone, 1);

    done_len = 1;
    req(24'h000090, 32'h12345678, 1'b1, 0, q, lat, ndone, nbusy, nreq);
    chk("wr_nreq", nreq, 1);
    chk("wr_sdc_we", {31'b0, last_we}, 32'h1);
    chk("wr_sdc_data", last_data, 32'h12345678);
    chk("wr_sdc_addr", {8'b0, last_addr}, 32'h000090);
    chk("wr_ndone", ndone, 1);
    chk("wr_busy_done1", nbusy, 4);

    req(24'h000090, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("alloc_hit_lat", lat, 2);
    chk("alloc_hit_q", q, 32'h12345678);
    chk("alloc_hit_nreq", nreq, 0);

    req(24'h000010, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("evict_nreq", nreq, 1);
    chk("evict_q", q, 32'hDEADBEEF);

    req(24'h000090, 32'hCAFEF00D, 1'b1, 2, q, lat, ndone, nbusy, nreq);
    chk("clr_wr_ndone", ndone, 1);
    chk("clr_wr_nreq", nreq, 1);
    chk("clr_wr_busy", nbusy, 132);

    req(24'h000090, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("post_clr_nreq", nreq, 1);
    chk("post_clr_q", q, 32'hCAFEF00D);

    cpu_addr = 24'h000090; cpu_we = 1'b0; cpu_start = 1'b1; cache_clear = 1'b1;
    @(posedge clk);
    #1;
    cpu_start = 1'b0; cache_clear = 1'b0;
    wait_sweep(nsw, ndone);
    chk("clr_wins_sweep", nsw, 128);
    chk("clr_wins_ndone", ndone, 0);
    req(24'h000090, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("clr_wins_miss", nreq, 1);

    cpu_addr = 24'h000010; cpu_we = 1'b0; cpu_start = 1'b1;
    @(posedge clk);
    #1;
    cpu_start = 1'b0;
    @(posedge clk);
    #1;
    chk("memreq_sdc_start", {31'b0, sdc_start}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_sdc_start", {31'b0, sdc_start}, 32'h0);
    chk("abort_sdc_addr", {8'b0, sdc_addr}, 32'h0);
    chk("abort_cpu_q", cpu_q, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_sweep(nsw, ndone);
    chk("abort_sweep", nsw, 128);
    chk("abort_late_done", ndone, 0);
    req(24'h000010, 32'h0, 1'b0, 0, q, lat, ndone, nbusy, nreq);
    chk("abort_reread_nreq", nreq, 1);
    chk("abort_reread_q", q, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_l1_cache.md
SDRAM_L1_CACHE -- requirements
Module: sdram_l1_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 7, meaning log2 of the number of lines (one 32-bit word per line, direct-mapped).
REQ-002 SHALL have parameter TAG_BITS, default 24-INDEX_BITS, meaning address bits stored per line as tag.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cpu_addr, input, 24, word address of the request.
REQ-006 SHALL have port cpu_data, input, 32, write data.
REQ-007 SHALL have port cpu_we, input, 1, 1=write, 0=read.
REQ-008 SHALL have port cpu_start, input, 1, one-cycle request strobe.
REQ-009 SHALL have port cache_clear, input, 1, one-cycle invalidate-all strobe.
REQ-010 SHALL have port cpu_q, output, 32, read data, valid while cpu_done=1.
REQ-011 SHALL have port cpu_done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have ports sdc_addr (output, 24), sdc_data (output, 32), sdc_we (output, 1), sdc_start (output, 1): requests to the SDRAM controller.
REQ-014 SHALL have ports sdc_q (input, 32) and sdc_done (input, 1): SDRAM controller responses; sdc_done may stay high 1 or 2 cycles.

Function
REQ-015 SHALL implement states CLEAR, IDLE, LOOKUP, MEM_REQ, DONE_WAIT.
REQ-016 SHALL split the address as index=cpu_addr[INDEX_BITS-1:0] and tag=cpu_addr[23:INDEX_BITS], with one valid bit per line.
REQ-017 In IDLE, on cpu_start=1 SHALL latch addr/data/we and enter LOOKUP the next cycle; cpu_* inputs are don't-care afterwards.
REQ-018 Tag/data storage SHALL have a registered read, so the latched index is presented in the cycle of REQ-017 and compared in LOOKUP.
REQ-019 Read hit (valid and tag equal): in LOOKUP SHALL load cpu_q with the line data and assert cpu_done in the next cycle (cpu_start to cpu_done = 2 cycles), returning to IDLE.
REQ-020 Read miss, or any write (write-through, write-allocate): SHALL enter MEM_REQ, driving sdc_addr = latched address, sdc_we = latched we, sdc_data = latched data, sdc_start=1.
REQ-021 sdc_addr/sdc_data/sdc_we SHALL stay stable from entry to MEM_REQ until sdc_done is first seen high; sdc_start SHALL deassert in the cycle after that.
REQ-022 On the first sdc_done=1, SHALL write the line (tag, valid=1, data = sdc_q for read, latched data for write), set cpu_q = sdc_q for read (unchanged for write), pulse cpu_done for one cycle, and enter DONE_WAIT.
REQ-023 DONE_WAIT SHALL stay until sdc_done=0, then go to IDLE; a second sdc_done cycle SHALL NOT generate another cpu_done or a line write.
REQ-024 A cpu_start outside IDLE SHALL be ignored; the CPU side guarantees none is issued while busy=1.
REQ-025 CLEAR SHALL sweep a counter from index 0 to 2^INDEX_BITS-1, clearing one valid bit per cycle, then go to IDLE.
REQ-026 cache_clear in IDLE SHALL enter CLEAR. Outside IDLE it SHALL be latched as pending and start CLEAR instead of IDLE when the current transaction ends.
REQ-027 cache_clear and cpu_start in the same IDLE cycle: clear wins; cpu_start is dropped.
REQ-028 A 24-bit address SHALL map to SDRAM unchanged; no address arithmetic beyond the split.

Reset
REQ-029 While reset=0: cpu_q=0, cpu_done=0, sdc_start=0, sdc_we=0, sdc_addr=0, sdc_data=0, pending clear=0, counter=0, state=CLEAR.
REQ-030 After reset releases, SHALL run a full CLEAR sweep (busy=1 for 2^INDEX_BITS cycles) before accepting requests.
REQ-031 Reset asserted mid-transaction SHALL abort immediately to the REQ-029 values; the controller's late sdc_done SHALL be absorbed as in REQ-023 or ignored in CLEAR.

Verification
REQ-032 Reset release: busy=1 for exactly 128 cycles, then 0. Read 0x000010 misses: sdc_start=1, sdc_addr=0x000010, sdc_we=0.
REQ-033 Read miss: model returns 0xDEADBEEF with 2-cycle sdc_done -> exactly one cpu_done, cpu_q=0xDEADBEEF. Re-read 0x000010 -> cpu_done 2 cycles after cpu_start, no sdc_start.
REQ-034 Write 0x000090=0x12345678 (same index 0x10, different tag) -> sdc_we=1, sdc_data=0x12345678. A following read of 0x000090 hits with 0x12345678; a read of 0x000010 misses.
REQ-035 cache_clear during an outstanding write -> write completes with one cpu_done, then a 128-cycle sweep; the next read of 0x000090 misses.
REQ-036 sdc_done held 1 vs 2 cycles -> a single cpu_done and single line update either way; busy drops only after sdc_done=0.
REQ-037 reset=0 in MEM_REQ -> outputs at reset values within the same cycle (asynchronous), followed by a full sweep.
